// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - MiniUart receive controller: baud strobe, byte capture FSM, RX FIFO, CPU registers
module uart_rx_ctrl #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd53
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        en_rx,
    input  logic [7:0]  rx_data,
    input  logic        rx_rs,
    output logic        over_read
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_DIV    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURE  = 2'd1,
        S_ACK      = 2'd2,
        S_WAIT_CLR = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ctrl_q, ctrl_d;
    logic [15:0]    div_q, div_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           rs_q;
    logic           overrun_q, overrun_d;
    logic           irq_q, irq_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     mem_q [FIFO_DEPTH];

    logic           capture;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic           ovr_set;
    logic           ovr_clr;
    logic           wr_ctrl;
    logic           wr_div;
    logic [7:0]     head;
    logic [4:0]     count5;
    logic [15:0]    unused_wdata;

    assign unused_wdata = wdata[31:16];

    assign wr_ctrl = we && (addr == A_CTRL);
    assign wr_div  = we && (addr == A_DIV);

    // Baud strobe: counter runs 0..DIV; the DIV cycle is the strobe.
    assign en_rx = ctrl_q[0] && (cnt_q == div_q);

    always_comb begin
        ctrl_d = ctrl_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        if (wr_ctrl) begin
            ctrl_d = wdata[1:0];
        end
        if (wr_div) begin
            div_d = wdata[15:0];
        end
        if (wr_ctrl || wr_div || !ctrl_q[0]) begin
            cnt_d = 16'd0;
        end else if (cnt_q == div_q) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        over_read = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rs_q) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                capture = 1'b1;
                state_d = S_ACK;
            end
            S_ACK: begin
                over_read = 1'b1;
                state_d   = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                if (!rs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = re && (addr == A_DATA) && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign push    = capture && (!full || pop);
    assign ovr_set = capture && full && !pop;
    assign ovr_clr = we && (addr == A_STATUS) && wdata[2];

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (ovr_set) begin
            overrun_d = 1'b1;
        end
        irq_d = ctrl_q[1] && (!empty || overrun_q);
    end

    assign irq    = irq_q;
    assign head   = empty ? 8'h00 : mem_q[rptr_q];
    assign count5 = 5'(count_q);

    always_comb begin
        rdata = 32'd0;
        case (addr)
            A_DATA:   rdata = {24'd0, head};
            A_STATUS: rdata = {23'd0, count5, 1'b0, overrun_q, full, !empty};
            A_CTRL:   rdata = {30'd0, ctrl_q};
            A_DIV:    rdata = {16'd0, div_q};
            default:  rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= 2'd0;
            div_q     <= DIV_RESET;
            cnt_q     <= 16'd0;
            rs_q      <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            rs_q      <= rx_rs;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        en_rx;
    logic [7:0]  rx_data;
    logic        rx_rs;
    logic        over_read;

    int n_tests;
    int n_fail;

    uart_rx_ctrl #(.FIFO_DEPTH(8), .DIV_RESET(16'd53)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .we        (we),
        .re        (re),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq),
        .en_rx     (en_rx),
        .rx_data   (rx_data),
        .rx_rs     (rx_rs),
        .over_read (over_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic peek(input logic [1:0] a);
        addr = a;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k       = 0;
        rx_data = b;
        rx_rs   = 1'b1;
        while (over_read !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        n_tests++;
        if (over_read !== 1'b1) begin
            n_fail++;
            $display("FAIL send_byte_ack byte=%02h over_read=%b required 1", b, over_read);
        end
        rx_rs = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        peek(2'd1);
        n_tests++;
        if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h want 0", rdata); end
        peek(2'd0);
        n_tests++;
        if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", rdata); end
        peek(2'd2);
        n_tests++;
        if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", rdata); end
        peek(2'd3);
        n_tests++;
        if (rdata !== 32'd53) begin n_fail++; $display("FAIL reset_div got %h want 35", rdata); end
        n_tests++;
        if ({irq, en_rx, over_read} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs irq/en_rx/over_read got %b want 000", {irq, en_rx, over_read});
        end
    endtask

    task automatic test_divisor();
        bus_write(2'd2, 32'd1);
        bus_write(2'd3, 32'd3);
        for (int k = 0; k < 12; k++) begin
            n_tests++;
            if (en_rx !== ((k % 4) == 3)) begin
                n_fail++;
                $display("FAIL div3_en_rx k=%0d got %b want %b", k, en_rx, ((k % 4) == 3));
            end
            tick();
        end
        bus_write(2'd3, 32'd0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (en_rx !== 1'b1) begin n_fail++; $display("FAIL div0_en_rx k=%0d got %b want 1", k, en_rx); end
            tick();
        end
        bus_write(2'd3, 32'd3);
        bus_write(2'd2, 32'd0);
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (en_rx !== 1'b0) begin n_fail++; $display("FAIL rxoff_en_rx k=%0d got %b want 0", k, en_rx); end
            tick();
        end
    endtask

    task automatic test_single_byte();
        rx_data = 8'hA5;
        rx_rs   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++;
            if (over_read !== (k == 3)) begin
                n_fail++;
                $display("FAIL single_latency cycle=%0d over_read=%b want %b", k, over_read, (k == 3));
            end
        end
        rx_rs = 1'b0;
        tick();
        n_tests++;
        if (over_read !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width got %b want 0", over_read); end
        tick();
        tick();
        peek(2'd1);
        n_tests++;
        if (rdata !== 32'h11) begin n_fail++; $display("FAIL single_status got %h want 11", rdata); end
        peek(2'd0);
        re = 1'b1;
        n_tests++;
        if (rdata !== 32'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", rdata); end
        tick();
        re = 1'b0;
        peek(2'd1);
        n_tests++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL single_status_after got %h want 0", rdata); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i));
        end
        peek(2'd1);
        n_tests++;
        if (rdata !== 32'h87) begin n_fail++; $display("FAIL fill_status got %h want 87", rdata); end
        for (int i = 1; i <= 8; i++) begin
            peek(2'd0);
            re = 1'b1;
            n_tests++;
            if (rdata !== 32'(i)) begin n_fail++; $display("FAIL fill_pop%0d got %h want %h", i, rdata, i); end
            tick();
            re = 1'b0;
        end
        peek(2'd1);
        n_tests++;
        if (rdata !== 32'h04) begin n_fail++; $display("FAIL drained_status got %h want 04", rdata); end
        bus_write(2'd1, 32'h4);
        peek(2'd1);
        n_tests++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL ovr_clear got %h want 0", rdata); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h10;
        exp_q[1] = 8'h11;
        exp_q[2] = 8'h12;
        exp_q[3] = 8'h55;
        send_byte(8'h10);
        send_byte(8'h11);
        send_byte(8'h12);
        rx_data = 8'h55;
        rx_rs   = 1'b1;
        tick();
        tick();
        peek(2'd0);
        re = 1'b1;
        n_tests++;
        if (rdata !== 32'h10) begin n_fail++; $display("FAIL simul_pop_data got %h want 10", rdata); end
        tick();
        re    = 1'b0;
        n_tests++;
        if (over_read !== 1'b1) begin n_fail++; $display("FAIL simul_ack got %b want 1", over_read); end
        rx_rs = 1'b0;
        peek(2'd1);
        n_tests++;
        if (rdata !== 32'h31) begin n_fail++; $display("FAIL simul_count got %h want 31", rdata); end
        tick();
        tick();
        tick();
        for (int i = 1; i < 4; i++) begin
            peek(2'd0);
            re = 1'b1;
            n_tests++;
            if (rdata !== {24'd0, exp_q[i]}) begin
                n_fail++;
                $display("FAIL simul_order%0d got %h want %h", i, rdata, exp_q[i]);
            end
            tick();
            re = 1'b0;
        end
    endtask

    task automatic test_irq();
        bus_write(2'd2, 32'd0);
        send_byte(8'h77);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled got %b want 0", irq); end
        bus_write(2'd2, 32'd3);
        tick();
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enable got %b want 1", irq); end
        peek(2'd0);
        re = 1'b1;
        tick();
        re = 1'b0;
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_pop_edge got %b want 1", irq); end
        tick();
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drained got %b want 0", irq); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        send_byte(8'h99);
        tick();
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_pre_irq got %b want 1", irq); end
        rx_data = 8'hC3;
        rx_rs   = 1'b1;
        tick();
        tick();
        tick();
        n_tests++;
        if (over_read !== 1'b1) begin n_fail++; $display("FAIL mid_ack got %b want 1", over_read); end
        rst = 1'b1;
        peek(2'd1);
        n_tests++;
        if ({over_read, irq} !== 2'b00 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset over_read/irq=%b status=%h want 00/0", {over_read, irq}, rdata);
        end
        tick();
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (over_read === 1'b1) begin
                pulses++;
                rx_rs = 1'b0;
            end
        end
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL mid_recapture_pulses got %0d want 1", pulses); end
        peek(2'd1);
        n_tests++;
        if (rdata !== 32'h11) begin n_fail++; $display("FAIL mid_recapture_status got %h want 11", rdata); end
        peek(2'd0);
        n_tests++;
        if (rdata !== 32'hC3) begin n_fail++; $display("FAIL mid_recapture_data got %h want c3", rdata); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        addr    = 2'd0;
        we      = 1'b0;
        re      = 1'b0;
        wdata   = 32'd0;
        rx_data = 8'd0;
        rx_rs   = 1'b0;
        test_reset();
        test_divisor();
        test_single_byte();
        test_fill_overrun();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the MiniUart. It generates the 8×-oversampling enable strobe (`en_rx`) for the receiving unit, drains each received byte through the `rs`/`over_read` handshake into a small FIFO, and exposes the FIFO plus status, control and divisor registers on the CPU bus with a level interrupt. It sits between the receiving unit and the bridge/device-bus decoder.

## Interface
- `FIFO_DEPTH`, 8: receive FIFO entries; must be a power of 2, 2..16.
- `DIV_RESET`, 16'd53: reset value of the divisor register (50 MHz, 115200 baud, 8× sampling).
- `clk`  in  1  system clock; the same clock as the receiving unit.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV.
- `we`  in  1  write strobe, valid with `addr`/`wdata` for one cycle.
- `re`  in  1  read strobe; a read of DATA with `re`=1 pops the FIFO.
- `wdata`  in  32  write data.
- `rdata`  out  32  combinational read data for `addr`.
- `irq`  out  1  level interrupt to the CPU.
- `en_rx`  out  1  sampling strobe to the receiving unit.
- `rx_data`  in  8  receiving-unit data register.
- `rx_rs`  in  1  receiving-unit byte-available status.
- `over_read`  out  1  one-cycle pulse that clears `rx_rs`.

## Operation
- **Registers**
  - DATA read: `{24'b0, head}` (0 when empty). `re` pops when non-empty. Writes are ignored.
  - STATUS read: bit0 = nonempty, bit1 = full, bit2 = overrun, bits[8:4] = count, others 0. Writing 1 to bit2 clears overrun.
  - CTRL, bits[1:0]: bit0 = rx_en, bit1 = irq_en. Reset value is 0.
  - DIV, bits[15:0]: divisor. Reset value is `DIV_RESET`.
- **Baud tick**
  - 16-bit counter counts 0..DIV. `en_rx`=1 for exactly the cycle the counter equals DIV, then the counter wraps to 0.
  - Strobe period is DIV+1 cycles. DIV=0 gives `en_rx`=1 every cycle.
  - When rx_en=0, the counter is held at 0 and `en_rx`=0.
  - A write to DIV or CTRL reloads the counter to 0.
- **Synchroniser:** `rx_rs` is a derived-clock flag, so it is registered once as `rs_q` before use.
- **Capture FSM:** states IDLE, CAPTURE, ACK, WAIT_CLR.
  - IDLE: move to CAPTURE when `rs_q`=1.
  - CAPTURE: latch `rx_data`. Push if not full; if full, drop the byte and set overrun. Go to ACK.
  - ACK: `over_read`=1 for this cycle only. Go to WAIT_CLR.
  - WAIT_CLR: stay while `rs_q`=1; go to IDLE when `rs_q`=0.
  - The FSM runs regardless of rx_en, so a pending byte is always drained.
- **FIFO:** read pointer, write pointer, and a count of width log2(`FIFO_DEPTH`)+1.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle with the FIFO non-empty: both happen and count is unchanged.
  - Push and pop in the same cycle with the FIFO empty: only the push happens. `rdata` shows 0 that cycle.
  - Push with the FIFO full and a simultaneous pop: the push is accepted and overrun is not set.
- **Interrupt:** `irq` = irq_en & (nonempty | overrun), registered.
- **Overrun priority:** overrun is sticky. If the set and a software clear occur in the same cycle, set wins.

## Timing
- Reset values: `rdata` follows `addr` with an empty FIFO (STATUS reads 0). `irq`=0, `en_rx`=0, `over_read`=0, FSM in IDLE, count=0, overrun=0.
- Latency from `rx_rs` rising to `over_read`: 3 cycles (sync, CAPTURE, ACK).
- Byte visible in STATUS/DATA: the cycle after CAPTURE.
- `irq` rises 1 cycle after nonempty rises. It falls 1 cycle after the last pop, provided overrun=0.
- `rdata` is combinational and does not reflect a pop until the next cycle.
- Writes take effect on the clock edge; reads in the same cycle return the old value.
- Reset asserted mid-operation:
  - FIFO contents are discarded and the FSM returns to IDLE at once.
  - `over_read` drops asynchronously.
  - A byte still flagged by `rx_rs` after reset release is captured normally.

## Test plan
- **Divisor:** reset, CTRL=1, DIV=3 → `en_rx` high 1 cycle in every 4. With CTRL=0, `en_rx` stays 0.
- **Single byte:** drive `rx_data`=8'hA5 and pulse `rx_rs` high until `over_read`.
  - `over_read` occurs exactly 3 cycles after the `rx_rs` rise, one cycle wide.
  - STATUS reads 0x11; DATA with `re` returns 0xA5, then STATUS reads 0.
- **Fill and overrun (`FIFO_DEPTH`=8):** push 9 bytes 0x01..0x09 with no reads.
  - STATUS reads 0x87 (count 8, full, nonempty, overrun).
  - Pops return 0x01..0x08.
  - Writing STATUS with 0x4 clears overrun.
- **Simultaneous push and pop:** capture 0x55 in the same cycle as a DATA pop on a 3-entry FIFO → count stays 3 and ordering is preserved.
- **Interrupt:**
  - irq_en=0 with data present → `irq`=0.
  - Set CTRL=3 → `irq`=1 next cycle.
  - Drain the FIFO → `irq`=0 one cycle after the last pop.
- **Reset mid-transfer:** assert `rst` during ACK → `over_read`, count and `irq` are 0 immediately. After release with `rx_rs` still high, the byte is captured once.
